// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
// Holds the fetch FSM state enum, the NOP word and the PC width.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EXEC,
    HALT
  } state_t;

endpackage

// File: rtl/fetch_unit_instret_counter.sv
// instret_counter: 64-bit retired-instruction counter.
// Ports: clk, rst (async high), en (count up), count (wraps at 2^64).
module instret_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [63:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner; fetches from variable-latency imem, one instr at a time.
// Ports: clk/rst, imem req/addr/rvalid/rdata, instr/instr_valid/pc/pc_plus4,
//        PCSrc/pc_target/stall from control+datapath, misalign_err, instret.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] pc_target,
  input  logic            stall,
  output logic            misalign_err,
  output logic [63:0]     instret
);

  state_t          state;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            retire;

  assign pc_plus4   = pc + 32'd4;
  assign imem_addr  = pc;
  assign next_pc    = PCSrc ? pc_target : pc_plus4;
  assign misaligned = |next_pc[1:0];

  // Only an aligned, unstalled EXEC edge counts as a retirement.
  assign retire = (state == EXEC) && !stall && !misaligned;

  // imem_req and instr_valid are registered alongside the state so
  // they always equal (state == FETCH) / (state == EXEC) without glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= NOP;
      instr_valid  <= 1'b0;
      imem_req     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          state    <= WAIT;
          imem_req <= 1'b0;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (misaligned) begin
              misalign_err <= 1'b1;
              state        <= HALT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  instret_counter u_instret (
    .clk   (clk),
    .rst   (rst),
    .en    (retire),
    .count (instret)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        PCSrc;
  logic [31:0] pc_target;
  logic        stall;
  logic        misalign_err;
  logic [63:0] instret;

  int checks;
  int errors;
  int req_cnt;
  int req_snap;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .PCSrc        (PCSrc),
    .pc_target    (pc_target),
    .stall        (stall),
    .misalign_err (misalign_err),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (imem_req) req_cnt++;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    req_cnt     = 0;
    rst         = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    PCSrc       = 1'b0;
    pc_target   = 32'h0;
    stall       = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state, cycle 1 = IDLE
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_merr", misalign_err, 0);
    chk("rst_instret", instret, 0);

    // First fetch at 0
    tick();
    chk("f0_req", imem_req, 1);
    chk("f0_addr", imem_addr, 32'h0);
    tick();
    chk("w0_req", imem_req, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("e0_valid", instr_valid, 1);
    chk("e0_instr", instr, 32'h0050_0093);
    chk("e0_pc4", pc_plus4, 32'h4);

    // Retire to 4
    tick();
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_instret", instret, 1);
    chk("f1_valid", instr_valid, 0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0010_8113;
    tick();
    imem_rvalid = 1'b0;
    chk("e1_instr", instr, 32'h0010_8113);

    // Retire to 8, one extra memory wait cycle
    tick();
    chk("f2_addr", imem_addr, 32'h8);
    chk("f2_instret", instret, 2);
    tick();
    tick();
    chk("w2_hold", instr_valid, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0463;
    tick();
    imem_rvalid = 1'b0;
    stall = 1'b1;
    chk("e2_valid", instr_valid, 1);
    tick();
    chk("st1_pc", pc, 32'h8);
    chk("st1_valid", instr_valid, 1);
    tick();
    chk("st2_pc", pc, 32'h8);
    chk("st2_instret", instret, 2);
    stall     = 1'b0;
    PCSrc     = 1'b1;
    pc_target = 32'h40;
    tick();
    PCSrc = 1'b0;
    chk("br_addr", imem_addr, 32'h40);
    chk("br_req", imem_req, 1);
    chk("br_instret", instret, 3);
    chk("req_count", req_cnt, 4);

    // Misaligned target
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0020_006f;
    tick();
    imem_rvalid = 1'b0;
    PCSrc       = 1'b1;
    pc_target   = 32'h42;
    tick();
    chk("ma_err", misalign_err, 1);
    chk("ma_pc", pc, 32'h40);
    chk("ma_instret", instret, 3);
    chk("ma_valid", instr_valid, 0);
    req_snap    = req_cnt;
    imem_rvalid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    imem_rvalid = 1'b0;
    PCSrc       = 1'b0;
    chk("ma_noreq", req_cnt, req_snap);
    chk("ma_sticky", misalign_err, 1);

    // Reset mid-WAIT, late response during IDLE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("r2_req", imem_req, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("rw_req", imem_req, 0);
    chk("rw_merr", misalign_err, 0);
    chk("rw_instret", instret, 0);
    tick();
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("rw_instr", instr, 32'h13);
    chk("rw_valid", instr_valid, 0);
    chk("rw_addr", imem_addr, 32'h0);
    chk("rw_freq", imem_req, 1);

    // Jump to 0xFFFFFFFC, then wrap to 0
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFFDF_F06F;
    tick();
    imem_rvalid = 1'b0;
    PCSrc       = 1'b1;
    pc_target   = 32'hFFFF_FFFC;
    tick();
    PCSrc = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    tick();
    imem_rvalid = 1'b0;
    chk("wr_pc4", pc_plus4, 32'h0);
    tick();
    chk("wr_next", imem_addr, 32'h0);
    chk("wr_instret", instret, 2);
    chk("wr_merr", misalign_err, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
